// File: rtl/cp_mux_2_to_1_arbiter_if.sv
// Request/grant and mux-control bundle between the two channels, the arbiter
// and the downstream 2:1 tristate mux.
interface cp_mux_2_to_1_arbiter_if;
    logic       i_req0;
    logic       i_req1;
    logic       o_gnt0;
    logic       o_gnt1;
    logic       o_sel;
    logic       o_en_;
    logic       o_busy;
    logic [7:0] o_burst_cnt;

    modport master (
        input  i_req0,
        input  i_req1,
        output o_gnt0,
        output o_gnt1,
        output o_sel,
        output o_en_,
        output o_busy,
        output o_burst_cnt
    );

    modport slave (
        output i_req0,
        output i_req1,
        input  o_gnt0,
        input  o_gnt1,
        input  o_sel,
        input  o_en_,
        input  o_busy,
        input  o_burst_cnt
    );
endinterface

// File: rtl/cp_mux_2_to_1_arbiter.sv
// Round-robin arbiter for a 2:1 tristate mux: bounded bursts under contention
// and a one-cycle disabled turnaround between every pair of grant periods.
module cp_mux_2_to_1_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    cp_mux_2_to_1_arbiter_if.master       bus
);
    // A burst limit of zero would never end a contended burst, so clamp it to one.
    localparam logic [7:0] BURST_LIM = (MAX_BURST == 32'd0) ? 8'd1 : 8'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2,
        TURN = 2'd3
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    logic       last_r;
    logic       last_nxt_s;
    logic [7:0] cnt_r;
    logic [7:0] cnt_nxt_s;
    logic       sel_r;
    logic       sel_nxt_s;
    logic       gnt0_r;
    logic       gnt1_r;
    logic       en_n_r;
    logic       busy_r;

    // Next-state and last-served selection.
    always_comb begin
        state_nxt_s = state_r;
        last_nxt_s  = last_r;
        case (state_r)
            IDLE: begin
                if (bus.i_req0 && bus.i_req1) begin
                    state_nxt_s = last_r ? GNT0 : GNT1;
                end else if (bus.i_req0) begin
                    state_nxt_s = GNT0;
                end else if (bus.i_req1) begin
                    state_nxt_s = GNT1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GNT0: begin
                if (!bus.i_req0 || ((cnt_r == BURST_LIM) && bus.i_req1)) begin
                    state_nxt_s = TURN;
                    last_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = GNT0;
                end
            end
            GNT1: begin
                if (!bus.i_req1 || ((cnt_r == BURST_LIM) && bus.i_req0)) begin
                    state_nxt_s = TURN;
                    last_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = GNT1;
                end
            end
            TURN: begin
                // last_r already names the channel that just released; the other goes first.
                if (last_r) begin
                    if (bus.i_req0) begin
                        state_nxt_s = GNT0;
                    end else if (bus.i_req1) begin
                        state_nxt_s = GNT1;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    if (bus.i_req1) begin
                        state_nxt_s = GNT1;
                    end else if (bus.i_req0) begin
                        state_nxt_s = GNT0;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Burst counter and mux select derived from the state being entered.
    always_comb begin
        cnt_nxt_s = 8'd0;
        sel_nxt_s = sel_r;
        if ((state_nxt_s == GNT0) || (state_nxt_s == GNT1)) begin
            if (state_nxt_s == state_r) begin
                cnt_nxt_s = (cnt_r < BURST_LIM) ? (cnt_r + 8'd1) : cnt_r;
            end else begin
                cnt_nxt_s = 8'd1;
            end
            sel_nxt_s = (state_nxt_s == GNT1) ? 1'b1 : 1'b0;
        end else begin
            cnt_nxt_s = 8'd0;
            sel_nxt_s = sel_r;
        end
    end

    // State register with registered, state-decoded outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= IDLE;
            last_r  <= 1'b1;
            cnt_r   <= 8'd0;
            sel_r   <= 1'b0;
            gnt0_r  <= 1'b0;
            gnt1_r  <= 1'b0;
            en_n_r  <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            last_r  <= last_nxt_s;
            cnt_r   <= cnt_nxt_s;
            sel_r   <= sel_nxt_s;
            gnt0_r  <= (state_nxt_s == GNT0);
            gnt1_r  <= (state_nxt_s == GNT1);
            en_n_r  <= !((state_nxt_s == GNT0) || (state_nxt_s == GNT1));
            busy_r  <= (state_nxt_s != IDLE);
        end
    end

    assign bus.o_gnt0      = gnt0_r;
    assign bus.o_gnt1      = gnt1_r;
    assign bus.o_sel       = sel_r;
    assign bus.o_en_       = en_n_r;
    assign bus.o_busy      = busy_r;
    assign bus.o_burst_cnt = cnt_r;
endmodule

// File: tb/tb_cp_mux_2_to_1_arbiter.sv
// Randomized bench for the 2:1 mux arbiter against a cycle-level ownership
// model, including asynchronous resets dropped in between clock edges.
module tb_cp_mux_2_to_1_arbiter;
    localparam int MB = 4;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;

    cp_mux_2_to_1_arbiter_if bus();

    cp_mux_2_to_1_arbiter #(.MAX_BURST(MB)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus.master)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: who owns the line, whether a turnaround is pending, etc.
    int m_owner;
    int m_turn;
    int m_prev;
    int m_last;
    int m_cnt;
    int m_sel;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_turn  = 0;
        m_prev  = 0;
        m_last  = 1;
        m_cnt   = 0;
        m_sel   = 0;
    endtask

    task automatic model_grant(input int c);
        m_owner = c;
        m_cnt   = 1;
        m_sel   = c;
    endtask

    // Advance the model across one rising edge with the given request levels.
    task automatic model_step(input int r0, input int r1);
        int req[2];
        int o;
        req[0] = r0;
        req[1] = r1;
        if (m_owner >= 0) begin
            if (req[m_owner] == 0 || (m_cnt == MB && req[1 - m_owner] == 1)) begin
                m_last  = m_owner;
                m_prev  = m_owner;
                m_turn  = 1;
                m_owner = -1;
                m_cnt   = 0;
            end else if (m_cnt < MB) begin
                m_cnt = m_cnt + 1;
            end
        end else if (m_turn == 1) begin
            m_turn = 0;
            o = 1 - m_prev;
            if (req[o] == 1)           model_grant(o);
            else if (req[m_prev] == 1) model_grant(m_prev);
        end else begin
            if (r0 == 1 && r1 == 1)    model_grant(1 - m_last);
            else if (r0 == 1)          model_grant(0);
            else if (r1 == 1)          model_grant(1);
        end
    endtask

    task automatic check_outputs();
        chk("gnt0",  32'(bus.o_gnt0),      32'(m_owner == 0));
        chk("gnt1",  32'(bus.o_gnt1),      32'(m_owner == 1));
        chk("en_",   32'(bus.o_en_),       32'(m_owner < 0));
        chk("busy",  32'(bus.o_busy),      32'(m_owner >= 0 || m_turn == 1));
        chk("cnt",   32'(bus.o_burst_cnt), 32'(m_cnt));
        chk("sel",   32'(bus.o_sel),       32'(m_sel));
    endtask

    initial begin
        int mode;
        int hold_ch;
        logic r0;
        logic r1;

        bus.i_req0 = 1'b0;
        bus.i_req1 = 1'b0;
        r0 = 1'b0;
        r1 = 1'b0;
        mode = 0;
        hold_ch = 0;
        model_reset();
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;

        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge i_clk);
            check_outputs();

            // Asynchronous reset pulse wholly between two edges.
            if ($urandom_range(0, 99) == 0) begin
                #2 i_rst = 1'b1;
                #1;
                chk("rst_gnt0", 32'(bus.o_gnt0),      32'd0);
                chk("rst_gnt1", 32'(bus.o_gnt1),      32'd0);
                chk("rst_en_",  32'(bus.o_en_),       32'd1);
                chk("rst_sel",  32'(bus.o_sel),       32'd0);
                chk("rst_busy", 32'(bus.o_busy),      32'd0);
                chk("rst_cnt",  32'(bus.o_burst_cnt), 32'd0);
                i_rst = 1'b0;
                model_reset();
            end

            if (cyc % 50 == 0) begin
                mode    = $urandom_range(0, 4);
                hold_ch = $urandom_range(0, 1);
            end
            case (mode)
                0: begin
                    r0 = 1'($urandom_range(0, 1));
                    r1 = 1'($urandom_range(0, 1));
                end
                1: begin
                    r0 = 1'b1;
                    r1 = 1'b1;
                end
                2: begin
                    r0 = (hold_ch == 0);
                    r1 = (hold_ch == 1);
                end
                3: begin
                    if ($urandom_range(0, 9) == 0) r0 = ~r0;
                    if ($urandom_range(0, 9) == 0) r1 = ~r1;
                end
                default: begin
                    r0 = ($urandom_range(0, 3) == 0);
                    r1 = ($urandom_range(0, 3) == 0);
                end
            endcase
            bus.i_req0 = r0;
            bus.i_req1 = r1;
            model_step(int'(r0), int'(r1));
        end

        @(negedge i_clk);
        check_outputs();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
